// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU result source, the result buffer and its consumer.
// The out_par wire exists only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_buffer_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_y;
    logic [SEL_W-1:0] in_sel;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [SEL_W-1:0] out_sel;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;
`ifdef ALU_RESULT_PARITY_EN
    logic             out_par;
`endif

    modport master (
        output in_valid, in_y, in_sel, clr, out_ready,
        input  in_ready, out_valid, out_y, out_sel, out_zero, out_neg,
               count, acc, acc_ovf
`ifdef ALU_RESULT_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  in_valid, in_y, in_sel, clr, out_ready,
        output in_ready, out_valid, out_y, out_sel, out_zero, out_neg,
               count, acc, acc_ovf
`ifdef ALU_RESULT_PARITY_EN
        , output out_par
`endif
    );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO buffer for ALU results with capture-time flags and a running wrap-around sum.
// Optional per-entry even parity output enabled by defining ALU_RESULT_PARITY_EN.
module alu_result_buffer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int DEPTH = 4,
    parameter int ACC_W = 12
) (
    input logic                clk,
    input logic                rst_n,
    alu_result_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [ACC_W:0]   acc_sum;
    logic             push, pop;

    logic [WIDTH-1:0] y_mem    [DEPTH];
    logic [SEL_W-1:0] sel_mem  [DEPTH];
    logic             zero_mem [DEPTH];
    logic             neg_mem  [DEPTH];
`ifdef ALU_RESULT_PARITY_EN
    logic             par_mem  [DEPTH];
`endif

    // Ready depends on occupancy alone, so a full buffer never passes a push through a pop.
    assign bus.in_ready  = (count_q < FULL_C);
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign acc_sum       = {1'b0, acc_q} + {{(ACC_W + 1 - WIDTH){1'b0}}, bus.in_y};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        if (bus.clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                acc_d     = acc_sum[ACC_W-1:0];
                acc_ovf_d = acc_ovf_q | acc_sum[ACC_W];
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    // Storage carries no reset; reads are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (push && !bus.clr) begin
            y_mem[wr_ptr_q]    <= bus.in_y;
            sel_mem[wr_ptr_q]  <= bus.in_sel;
            zero_mem[wr_ptr_q] <= (bus.in_y == '0);
            neg_mem[wr_ptr_q]  <= bus.in_y[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
            par_mem[wr_ptr_q]  <= ^bus.in_y;
`endif
        end
    end

    assign bus.out_y    = bus.out_valid ? y_mem[rd_ptr_q]   : '0;
    assign bus.out_sel  = bus.out_valid ? sel_mem[rd_ptr_q] : '0;
    assign bus.out_zero = bus.out_valid & zero_mem[rd_ptr_q];
    assign bus.out_neg  = bus.out_valid & neg_mem[rd_ptr_q];
`ifdef ALU_RESULT_PARITY_EN
    assign bus.out_par  = bus.out_valid & par_mem[rd_ptr_q];
`endif
    assign bus.count    = count_q;
    assign bus.acc      = acc_q;
    assign bus.acc_ovf  = acc_ovf_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: vector table plus hand sequences for reset, clr and overflow.
module tb_alu_result_buffer;
    logic clk;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;

    alu_result_buffer_if #(.WIDTH(8), .SEL_W(3), .DEPTH(4), .ACC_W(12)) bus();

    alu_result_buffer #(.WIDTH(8), .SEL_W(3), .DEPTH(4), .ACC_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       iv;
        logic [7:0] y;
        logic [2:0] sel;
        logic       ordy;
        logic       clr;
        logic       e_vld;
        logic [7:0] e_y;
        logic [2:0] e_sel;
        logic       e_z;
        logic       e_n;
        logic [2:0] e_cnt;
        logic       e_rdy;
        logic [11:0] e_acc;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] y, input logic [2:0] sel,
                         input logic ordy, input logic c);
        bus.in_valid  = iv;
        bus.in_y      = y;
        bus.in_sel    = sel;
        bus.out_ready = ordy;
        bus.clr       = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic vld, input logic [2:0] cnt,
                             input logic rdy, input logic [11:0] acc, input logic ovf);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(vld));
        chk({tag, " count"},     32'(bus.count),     32'(cnt));
        chk({tag, " in_ready"},  32'(bus.in_ready),  32'(rdy));
        chk({tag, " acc"},       32'(bus.acc),       32'(acc));
        chk({tag, " acc_ovf"},   32'(bus.acc_ovf),   32'(ovf));
    endtask

    task automatic chk_head(input string tag, input logic [7:0] y, input logic [2:0] sel,
                            input logic z, input logic n);
        chk({tag, " out_y"},    32'(bus.out_y),    32'(y));
        chk({tag, " out_sel"},  32'(bus.out_sel),  32'(sel));
        chk({tag, " out_zero"}, 32'(bus.out_zero), 32'(z));
        chk({tag, " out_neg"},  32'(bus.out_neg),  32'(n));
    endtask

    initial begin
        // iv  y      sel   ordy  clr | vld   y      sel   z     n     cnt   rdy   acc       ovf
        vecs.push_back('{1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 1'b1, 1'b0, 3'd1, 1'b1, 12'h000, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 12'h000, 1'b0});
        vecs.push_back('{1'b1, 8'h81, 3'd1, 1'b0, 1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 3'd1, 1'b1, 12'h081, 1'b0});
        vecs.push_back('{1'b1, 8'h02, 3'd3, 1'b0, 1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 3'd2, 1'b1, 12'h083, 1'b0});
        vecs.push_back('{1'b1, 8'h03, 3'd4, 1'b0, 1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 3'd3, 1'b1, 12'h086, 1'b0});
        vecs.push_back('{1'b1, 8'h04, 3'd5, 1'b0, 1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 3'd4, 1'b0, 12'h08A, 1'b0});
        vecs.push_back('{1'b1, 8'h55, 3'd6, 1'b0, 1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 3'd4, 1'b0, 12'h08A, 1'b0});
        vecs.push_back('{1'b1, 8'h55, 3'd6, 1'b1, 1'b0, 1'b1, 8'h02, 3'd3, 1'b0, 1'b0, 3'd3, 1'b1, 12'h08A, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h03, 3'd4, 1'b0, 1'b0, 3'd2, 1'b1, 12'h08A, 1'b0});
        vecs.push_back('{1'b1, 8'h10, 3'd7, 1'b1, 1'b0, 1'b1, 8'h04, 3'd5, 1'b0, 1'b0, 3'd2, 1'b1, 12'h09A, 1'b0});
        vecs.push_back('{1'b1, 8'h20, 3'd0, 1'b1, 1'b0, 1'b1, 8'h10, 3'd7, 1'b0, 1'b0, 3'd2, 1'b1, 12'h0BA, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h20, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 12'h0BA, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 12'h0BA, 1'b0});
        vecs.push_back('{1'b1, 8'h33, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 12'h000, 1'b0});

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        #2;
        chk_state("reset", 1'b0, 3'd0, 1'b1, 12'h000, 1'b0);
        chk_head("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].y, vecs[i].sel, vecs[i].ordy, vecs[i].clr);
            step();
            chk_state($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_cnt, vecs[i].e_rdy,
                      vecs[i].e_acc, vecs[i].e_ovf);
            chk_head($sformatf("v%0d", i), vecs[i].e_y, vecs[i].e_sel, vecs[i].e_z, vecs[i].e_n);
        end

        // Asynchronous reset with three entries held.
        drive(1'b1, 8'h11, 3'd1, 1'b0, 1'b0); step();
        drive(1'b1, 8'h22, 3'd2, 1'b0, 1'b0); step();
        drive(1'b1, 8'h33, 3'd3, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk_state("pre_rst", 1'b1, 3'd3, 1'b1, 12'h066, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_state("mid_rst", 1'b0, 3'd0, 1'b1, 12'h000, 1'b0);
        chk_head("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // clr while full: in_ready still reflects count during the clr cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'(k + 1), 3'd1, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h44, 3'd2, 1'b0, 1'b1);
        #1;
        chk("full_clr in_ready", 32'(bus.in_ready), 32'(1'b0));
        step();
        chk_state("full_clr", 1'b0, 3'd0, 1'b1, 12'h000, 1'b0);

        // Seventeen 0xFF pushes with free popping; carry out on the 17th.
        for (int k = 1; k <= 17; k++) begin
            drive(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0);
            step();
            chk_state($sformatf("ff%0d", k), 1'b1, 3'd1, 1'b1, 12'((255 * k) % 4096), (k >= 17));
            chk_head($sformatf("ff%0d", k), 8'hFF, 3'd7, 1'b0, 1'b1);
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_state("ovf_hold", 1'b1, 3'd1, 1'b1, 12'h0EF, 1'b1);
        drive(1'b1, 8'h12, 3'd3, 1'b0, 1'b1);
        #1;
        chk("clr_cycle in_ready", 32'(bus.in_ready), 32'(1'b1));
        step();
        chk_state("clr_push", 1'b0, 3'd0, 1'b1, 12'h000, 1'b0);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_state("after_clr", 1'b0, 3'd0, 1'b1, 12'h000, 1'b0);
        chk_head("after_clr", 8'h00, 3'd0, 1'b0, 1'b0);

`ifdef ALU_RESULT_PARITY_EN
        chk("par empty", 32'(bus.out_par), 32'(1'b0));
        drive(1'b1, 8'h07, 3'd1, 1'b0, 1'b0);
        step();
        chk("par 0x07", 32'(bus.out_par), 32'(1'b1));
        drive(1'b1, 8'h03, 3'd2, 1'b1, 1'b0);
        step();
        chk("par 0x03 y", 32'(bus.out_y), 32'(8'h03));
        chk("par 0x03", 32'(bus.out_par), 32'(1'b0));
        drive(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        step();
        chk("par drained", 32'(bus.out_par), 32'(1'b0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
